pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program-counter stack for the sequencer: holds one PC per call level, gives the active PC to instruction fetch, and supports increment, absolute jump, relative branch, call and return in one cycle each. It generalises the fixed 9-bit / 8-level banked PC. It adds configurable width and depth, call/return with automatic return-address save, signed relative branches, full/empty status, and a sticky, clearable error with a cause code.

## Interface
- `PC_WIDTH`, 9: PC width in bits. Must be ≥ 2.
- `DEPTH`, 8: number of call levels. Must be ≥ 2.
- `OFF_WIDTH`, 6: width of the signed relative-branch offset. Must be ≤ `PC_WIDTH`.
- `RESET_VECTOR`, 0: value loaded into every level on reset.
- `LVL_W` (localparam) = `$clog2(DEPTH)`.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `pc_inc` input 1: PC += 1.
- `pc_set` input 1: PC = `pc_set_value`.
- `pc_set_value` input `PC_WIDTH`: absolute jump target.
- `pc_rel` input 1: PC += sign-extended `pc_offset`.
- `pc_offset` input `OFF_WIDTH`: two's-complement branch offset.
- `pc_call` input 1: push the return address and jump to `pc_set_value`.
- `pc_ret` input 1: pop to the previous level.
- `err_clr` input 1: clear the sticky error.
- `pc_out` output `PC_WIDTH`: active PC, equal to `bank[lvl]`. Combinational from registers.
- `lvl` output `LVL_W`: current level index.
- `full` output 1: `lvl == DEPTH-1`.
- `empty` output 1: `lvl == 0`.
- `err` output 1: sticky error flag.
- `err_code` output 2: cause of the first error. `00` none, `01` overflow, `10` underflow.

## Operation
- State: `bank[0..DEPTH-1]` of `PC_WIDTH` bits, `lvl`, `err`, `err_code`.
- Command priority when several are asserted in one cycle: `pc_call` > `pc_ret` > `pc_set` > `pc_rel` > `pc_inc`. Only the highest-priority command executes; the others are ignored without error.
- `pc_inc`: `bank[lvl] <= bank[lvl] + 1`, modulo 2^`PC_WIDTH` (e.g. 511 → 0 at width 9).
- `pc_set`: `bank[lvl] <= pc_set_value`.
- `pc_rel`: `bank[lvl] <= bank[lvl] + sext(pc_offset)`, modulo 2^`PC_WIDTH`. Wraps in both directions.
- `pc_call` when not full:
  - `bank[lvl] <= bank[lvl] + 1` (saves the return address);
  - `bank[lvl+1] <= pc_set_value`;
  - `lvl <= lvl + 1`.
- `pc_call` when full: overflow. No change to `bank` or `lvl`.
- `pc_ret` when not empty: `lvl <= lvl - 1`. The popped level keeps its stale contents. No PC arithmetic is done; the saved return address is already in place.
- `pc_ret` when empty: underflow. No change to `bank` or `lvl`.
- Error handling:
  - On overflow or underflow, `err <= 1`.
  - `err_code` is loaded only if `err` was 0, so the first cause is kept.
  - The block keeps executing later commands while `err = 1`.
  - `err_clr` sets `err <= 0` and `err_code <= 00`.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: `err = 1` and the code is the new cause.
- No command asserted: all state holds.

## Timing
- Every command takes effect at the rising edge where it is sampled. `pc_out`, `lvl`, `full`, `empty`, `err` and `err_code` show the result immediately after that edge. There is no additional latency.
- `pc_out` is purely combinational from `bank` and `lvl`; inputs do not pass through to it combinationally.
- Reset (synchronous, takes priority over all commands):
  - every `bank` entry ← `RESET_VECTOR`;
  - `lvl` ← 0, `err` ← 0, `err_code` ← 00.
  - Resulting outputs: `pc_out = RESET_VECTOR`, `empty = 1`, `full = 0`.
- Reset asserted mid-sequence, for example together with `pc_call`: the reset state results and the command is discarded.
- Back-to-back commands are legal every cycle. Example: `pc_call` followed next cycle by `pc_ret` returns to the caller's PC + 1.

## Test plan
- Reset, then `pc_inc` for 3 cycles → `pc_out` = 0, 1, 2, 3. Hold `pc_set` = 510 then `pc_inc` twice → `pc_out` = 510, 511, 0 (wrap).
- `pc_set` = 100, then `pc_rel` with offset −5 (`6'b111011`) → 95. Then offset +31 → 126. From PC = 2, offset −4 → 510.
- At PC = 40, `pc_call` to 200 → `pc_out` = 200, `lvl` = 1. Then `pc_inc` → 201. Then `pc_ret` → `pc_out` = 41, `lvl` = 0, `empty` = 1.
- Make 7 nested calls → `lvl` = 7, `full` = 1. An 8th `pc_call` → `err` = 1, `err_code` = 01, with `pc_out` and `lvl` unchanged. Then 8 `pc_ret` → `err_code` stays 01 and `lvl` ends at 0. Then `err_clr` together with `pc_ret` at `lvl` = 0 → `err` = 1, `err_code` = 10.
- Assert `pc_call` (target 300), `pc_set` (300) and `pc_inc` in the same cycle at PC = 10 → only the call executes: `lvl` + 1, `pc_out` = 300, return address 11.
- Assert `rst` in the same cycle as `pc_call` at `lvl` = 3 with `err` = 1 → next cycle `lvl` = 0, `pc_out` = `RESET_VECTOR`, `err` = 0, `err_code` = 00.

Source files
------------

// File: rtl/pc_stack.sv
// ----------------------------------------------------------------------------
// pc_stack
//   Program-counter stack for the sequencer. Each call level holds one PC.
//   The PC of the active level goes to instruction fetch. Increment,
//   absolute jump, signed relative branch, call and return each complete in
//   one cycle. Overflow and underflow raise a sticky error. The error keeps
//   the code of the first cause until it is cleared.
//
//   Ports
//     clk           single clock; all state changes on its rising edge
//     rst           synchronous active-high reset; wins over every command
//     pc_inc        PC += 1
//     pc_set        PC = pc_set_value
//     pc_set_value  absolute jump / call target
//     pc_rel        PC += sign-extended pc_offset
//     pc_offset     two's-complement branch offset
//     pc_call       save PC+1 at this level, go up one level at pc_set_value
//     pc_ret        drop back one level (return address already in place)
//     err_clr       clear sticky error and its code
//     pc_out        active PC, bank[lvl] (combinational from registers)
//     lvl           current level index
//     full, empty   lvl at top / bottom
//     err, err_code sticky error flag; cause 01 overflow, 10 underflow
//
//   Command priority: call > ret > set > rel > inc.
// ----------------------------------------------------------------------------
module pc_stack #(
   parameter int                     PC_WIDTH     = 9,
   parameter int                     DEPTH        = 8,
   parameter int                     OFF_WIDTH    = 6,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
   localparam int                    LVL_W        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pc_inc,
   input  logic                 pc_set,
   input  logic [PC_WIDTH-1:0]  pc_set_value,
   input  logic                 pc_rel,
   input  logic [OFF_WIDTH-1:0] pc_offset,
   input  logic                 pc_call,
   input  logic                 pc_ret,
   input  logic                 err_clr,
   output logic [PC_WIDTH-1:0]  pc_out,
   output logic [LVL_W-1:0]     lvl,
   output logic                 full,
   output logic                 empty,
   output logic                 err,
   output logic [1:0]           err_code
);

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;

   logic [PC_WIDTH-1:0] bank [DEPTH];
   logic [LVL_W-1:0]    lvl_q;
   logic                err_q;
   logic [1:0]          err_code_q;

   logic [PC_WIDTH-1:0] pc_cur;
   logic [PC_WIDTH-1:0] off_ext;
   logic                ovf;
   logic                unf;

   assign pc_cur   = bank[lvl_q];
   assign pc_out   = pc_cur;
   assign lvl      = lvl_q;
   assign full     = (lvl_q == LVL_W'(DEPTH-1));
   assign empty    = (lvl_q == '0);
   assign err      = err_q;
   assign err_code = err_code_q;

   // Casting the signed offset to the PC width sign-extends it. Two's-complement
   // addition modulo 2^PC_WIDTH then wraps correctly in both directions.
   assign off_ext = PC_WIDTH'($signed(pc_offset));

   // A ret that loses to a call is not executed, so it cannot underflow.
   assign ovf = pc_call && full;
   assign unf = !pc_call && pc_ret && empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= RESET_VECTOR;
         end
         lvl_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         if (pc_call) begin
            if (!full) begin
               bank[lvl_q]                <= pc_cur + PC_WIDTH'(1);
               bank[lvl_q + LVL_W'(1)]    <= pc_set_value;
               lvl_q                      <= lvl_q + LVL_W'(1);
            end
         end else if (pc_ret) begin
            if (!empty) begin
               lvl_q <= lvl_q - LVL_W'(1);
            end
         end else if (pc_set) begin
            bank[lvl_q] <= pc_set_value;
         end else if (pc_rel) begin
            bank[lvl_q] <= pc_cur + off_ext;
         end else if (pc_inc) begin
            bank[lvl_q] <= pc_cur + PC_WIDTH'(1);
         end

         // A new error beats a simultaneous clear. Without a clear, the code
         // of the first error is kept.
         if (ovf || unf) begin
            err_q <= 1'b1;
            if (err_clr || !err_q) begin
               err_code_q <= ovf ? ERR_OVF : ERR_UNF;
            end
         end else if (err_clr) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
         end
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// ----------------------------------------------------------------------------
// tb_pc_stack
//   Directed bench for pc_stack with default parameters: 9-bit PC, 8 levels,
//   6-bit offset, and reset vector 0. Inputs change 1 ns after the rising
//   edge. Outputs are sampled at that same point, after the edge has taken
//   effect.
// ----------------------------------------------------------------------------
module tb_pc_stack;

   logic       clk = 1'b0;
   logic       rst;
   logic       pc_inc;
   logic       pc_set;
   logic [8:0] pc_set_value;
   logic       pc_rel;
   logic [5:0] pc_offset;
   logic       pc_call;
   logic       pc_ret;
   logic       err_clr;
   logic [8:0] pc_out;
   logic [2:0] lvl;
   logic       full;
   logic       empty;
   logic       err;
   logic [1:0] err_code;

   int tests_run = 0;
   int tests_failed = 0;

   pc_stack dut (
      .clk          (clk),
      .rst          (rst),
      .pc_inc       (pc_inc),
      .pc_set       (pc_set),
      .pc_set_value (pc_set_value),
      .pc_rel       (pc_rel),
      .pc_offset    (pc_offset),
      .pc_call      (pc_call),
      .pc_ret       (pc_ret),
      .err_clr      (err_clr),
      .pc_out       (pc_out),
      .lvl          (lvl),
      .full         (full),
      .empty        (empty),
      .err          (err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      rst          = 1'b0;
      pc_inc       = 1'b0;
      pc_set       = 1'b0;
      pc_set_value = '0;
      pc_rel       = 1'b0;
      pc_offset    = '0;
      pc_call      = 1'b0;
      pc_ret       = 1'b0;
      err_clr      = 1'b0;
   endtask

   // Apply the inputs currently driven for one rising edge, then clear them.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_inc();
      pc_inc = 1'b1; step();
   endtask

   task automatic do_set(input logic [8:0] v);
      pc_set = 1'b1; pc_set_value = v; step();
   endtask

   task automatic do_rel(input logic [5:0] o);
      pc_rel = 1'b1; pc_offset = o; step();
   endtask

   task automatic do_call(input logic [8:0] v);
      pc_call = 1'b1; pc_set_value = v; step();
   endtask

   task automatic do_ret();
      pc_ret = 1'b1; step();
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();

      check("rst_pc", pc_out, 0);
      check("rst_lvl", lvl, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_err", err, 0);
      check("rst_code", err_code, 0);

      do_inc(); check("inc1", pc_out, 1);
      do_inc(); check("inc2", pc_out, 2);
      do_inc(); check("inc3", pc_out, 3);
      step();   check("hold", pc_out, 3);

      do_set(9'd510); check("set510", pc_out, 510);
      do_inc();       check("inc511", pc_out, 511);
      do_inc();       check("inc_wrap", pc_out, 0);

      do_set(9'd100);     check("set100", pc_out, 100);
      do_rel(6'b111011);  check("rel_m5", pc_out, 95);
      do_rel(6'd31);      check("rel_p31", pc_out, 126);
      do_set(9'd2);
      do_rel(6'b111100);  check("rel_wrap_neg", pc_out, 510);
      do_rel(6'd3);       check("rel_wrap_pos", pc_out, 1);

      // set beats rel when both are asserted.
      pc_set = 1'b1; pc_set_value = 9'd5; pc_rel = 1'b1; pc_offset = 6'd3;
      step();
      check("prio_set_rel", pc_out, 5);

      do_set(9'd40);
      do_call(9'd200);
      check("call_pc", pc_out, 200);
      check("call_lvl", lvl, 1);
      check("call_empty", empty, 0);
      do_inc();  check("call_inc", pc_out, 201);
      do_ret();
      check("ret_pc", pc_out, 41);
      check("ret_lvl", lvl, 0);
      check("ret_empty", empty, 1);

      // Level 0 holds 41. After 7 nested calls: bank[0]=42,
      // bank[k]=101+k for k=1..6, and bank[7]=107.
      for (int i = 1; i <= 7; i++) begin
         do_call(9'(100 + i));
         check("nest_lvl", lvl, 32'(i));
      end
      check("nest_full", full, 1);
      check("nest_pc", pc_out, 107);
      check("nest_err0", err, 0);

      do_call(9'd400);
      check("ovf_err", err, 1);
      check("ovf_code", err_code, 1);
      check("ovf_pc", pc_out, 107);
      check("ovf_lvl", lvl, 7);

      do_ret();
      check("pop_lvl6", lvl, 6);
      check("pop_pc6", pc_out, 107);
      for (int i = 0; i < 6; i++) do_ret();
      check("pop_lvl0", lvl, 0);
      check("pop_pc0", pc_out, 42);
      do_ret();  // underflow while already in error
      check("unf_keep_code", err_code, 1);
      check("unf_keep_err", err, 1);
      check("unf_lvl", lvl, 0);

      pc_ret = 1'b1; err_clr = 1'b1; step();
      check("clr_vs_unf_err", err, 1);
      check("clr_vs_unf_code", err_code, 2);

      err_clr = 1'b1; step();
      check("clr_err", err, 0);
      check("clr_code", err_code, 0);

      do_set(9'd10);
      pc_call = 1'b1; pc_set = 1'b1; pc_inc = 1'b1; pc_set_value = 9'd300;
      step();
      check("prio_lvl", lvl, 1);
      check("prio_pc", pc_out, 300);
      do_ret();
      check("prio_ret_pc", pc_out, 11);

      // Underflow raises err, then climb to level 3 and reset with a call.
      do_ret();
      check("unf_err", err, 1);
      check("unf_code", err_code, 2);
      do_call(9'd20);
      do_call(9'd30);
      do_call(9'd50);
      check("pre_rst_lvl", lvl, 3);
      rst = 1'b1; pc_call = 1'b1; pc_set_value = 9'd77; step();
      check("mid_rst_lvl", lvl, 0);
      check("mid_rst_pc", pc_out, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_code", err_code, 0);
      check("mid_rst_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
